igpu_residual_compressor: RTL and testbench
===========================================

# igpu_residual_compressor

Single-clock pipelined compressor that codes a 32-pixel RGBA8 block into one 512-bit line using per-channel minimum + residual coding. It sits between the pixel source and the link packetiser. Each cycle it accepts one block, and two cycles later it emits the packed line plus a flag. The flag marks whether the block compressed or must be sent raw by the downstream path.

## Interface
- No parameters. Block size is fixed at 32 pixels × 4 channels × 8 bits.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pixels`  in  1024  `types::pixels_t`. Field `channels.{r,g,b,a}_channel[i]` holds pixel i's 8-bit channel, i = 0..31.
- `lines`  out  512  compressed line. All zero when flag is 00.
- `flag`  out  2  compression status:
  - 2'b01: block compressed into `lines`.
  - 2'b00: not compressible, or reset.
  - 10/11: never driven.

## Operation
- Per channel c∈{r,g,b,a}:
  - min_c = minimum over 32 pixels; max_c = maximum.
  - span_c = max_c − min_c (8-bit unsigned).
- bits_required_c = bit width of span_c: 0 if span = 0, else floor(log2(span)) + 1. Encoded in 3 bits.
- Compressible iff both hold:
  - every bits_required_c ≤ 7, i.e. span < 128;
  - W = Σ bits_required_c ≤ 14.
- Residual: res_c[i] = ch_c[i] − min_c, truncated to bits_required_c bits.
- Pixel slot pix[i], 14 bits: {res_r, res_g, res_b, res_a} concatenated MSB-first, left-justified, zero-padded on the right. A zero-width channel contributes no bits.
- Line layout when compressible:
  - [511:504] min_r, [503:496] min_g, [495:488] min_b, [487:480] min_a.
  - [479:468] bits_required {r,g,b,a}, 3 bits each, r in [479:477].
  - [467:464] 4'b0000.
  - Header is the 48 bits [511:464].
  - pix[i] at [463−14i −: 14], i = 0..31. Pixel 31 ends at bit 16.
  - [15:0] zero.
- Not compressible: lines = 512'b0, flag = 2'b00.

## Timing
- Reset, asynchronous: all pipeline registers clear. lines = 0 and flag = 00 immediately and while rst is high.
- Stage 1, registered at edge N: header (mins, bits_required, compressible bit) and a copy of pixels.
- Stage 2, registered at edge N+1: residual packing into the line register (cc_reg). lines and flag valid after edge N+1. Latency 2 cycles, throughput 1 block per cycle, no handshake.
- A new block every cycle is legal. Outputs always correspond to the block presented 2 edges earlier.
- Reset mid-pipeline discards in-flight blocks. The first valid output comes 2 edges after reset deasserts, with pixels stable.
- Boundaries:
  - span = 127 → 7 bits, legal; span = 128 → fail.
  - W = 14 → legal; W = 15 → fail.

## Structure
- Package `types`:
  - `pixels_t` (packed struct `channels` of four `logic [31:0][7:0]` arrays);
  - header struct (`min_values` with 4×8 mins and 12-bit `bits_required`);
  - line union/struct (`l.pix[32]` of 14 bits plus header);
  - constants: 32 pixels, 14-bit slot, 48-bit header, flag encodings.
- Sub-module `residual`, instance `residual_inst`: computes the header and the compressible bit, stage 1.
- Top `igpu` does packing and the output registers (`cc_reg`).

## Test plan
- All 32 pixels = (10,20,30,40):
  - flag 01, header mins 0A/14/1E/28, bits_required 0;
  - lines[463:0] = 0.
- r = i, g = 2i, b = 200, a = 255 for pixel i:
  - bits_required r=5, g=6, b=0, a=0 (W = 11);
  - pix[i] = {i[4:0], (2i)[5:0], 3'b0}.
- r spans 0..127, all other channels constant:
  - bits_required r = 7, flag 01.
- r spans 0..128:
  - flag 00, lines = 0.
- Widths 4/4/3/3 (W = 14): packs, flag 01. Widths 4/4/4/3 (W = 15): flag 00.
- Assert rst one cycle after driving a compressible block:
  - lines/flag go 0/00 asynchronously;
  - after release, the next block's output appears exactly 2 edges later.

Source files
------------

// File: rtl/igpu_residual_compressor_pkg.sv
// Shared types and constants for the residual compressor.
// A 32-pixel RGBA8 block is coded into one 512-bit line.
package igpu_residual_compressor_pkg;

  localparam int NUM_PIXELS       = 32;
  localparam int SLOT_BITS        = 14;
  localparam int HEADER_BITS      = 48;
  localparam int MAX_CHANNEL_BITS = 7;
  localparam int RESERVED_BITS    = HEADER_BITS - 44;

  localparam logic [1:0] FLAG_RAW        = 2'b00;
  localparam logic [1:0] FLAG_COMPRESSED = 2'b01;

  typedef logic [NUM_PIXELS-1:0][7:0] channel_t;

  typedef struct packed {
    channel_t r_channel;
    channel_t g_channel;
    channel_t b_channel;
    channel_t a_channel;
  } channels_t;

  typedef struct packed {
    channels_t channels;
  } pixels_t;

  typedef struct packed {
    logic [7:0] min_r;
    logic [7:0] min_g;
    logic [7:0] min_b;
    logic [7:0] min_a;
  } min_values_t;

  typedef struct packed {
    min_values_t                min_values;
    logic [11:0]                bits_required;
    logic [RESERVED_BITS-1:0]   reserved;
  } header_t;

  // pix[0] sits directly below the header, so the array is ascending.
  typedef struct packed {
    header_t                                 header;
    logic [0:NUM_PIXELS-1][SLOT_BITS-1:0]    pix;
    logic [15:0]                             pad;
  } line_t;

  // Width of an 8-bit span; a span of 128 or more reports 8.
  function automatic logic [3:0] bit_width(input logic [7:0] v);
    logic [3:0] w;
    w = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) w = 4'(k + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/igpu_residual_compressor_residual.sv
// Stage 1: per-channel minimum/maximum, residual widths and the
// compressible decision, registered together with a copy of the block.
module igpu_residual_compressor_residual (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] pixels,
  output logic [1023:0] pixels_q,
  output logic [47:0]   header_q,
  output logic          compressible_q
);
  import igpu_residual_compressor_pkg::*;

  pixels_t              px;
  logic [3:0][NUM_PIXELS-1:0][7:0] chan;
  logic [3:0][7:0]      mins;
  logic [3:0][7:0]      maxs;
  logic [3:0][3:0]      widths;
  logic [5:0]           width_sum;
  logic                 compressible;
  header_t              header;

  assign px   = pixels;
  // Channel index 3 is red down to 0 for alpha, matching header order.
  assign chan = {px.channels.r_channel, px.channels.g_channel,
                 px.channels.b_channel, px.channels.a_channel};

  always_comb begin
    mins         = '0;
    maxs         = '0;
    widths       = '0;
    width_sum    = '0;
    compressible = 1'b1;
    header       = '0;
    for (int c = 0; c < 4; c++) begin
      mins[c] = 8'hFF;
      maxs[c] = 8'h00;
      for (int i = 0; i < NUM_PIXELS; i++) begin
        if (chan[c][i] < mins[c]) mins[c] = chan[c][i];
        if (chan[c][i] > maxs[c]) maxs[c] = chan[c][i];
      end
      widths[c] = bit_width(maxs[c] - mins[c]);
      width_sum = width_sum + {2'b00, widths[c]};
      if (widths[c] > 4'(MAX_CHANNEL_BITS)) compressible = 1'b0;
      header.bits_required[3*c +: 3] = widths[c][2:0];
    end
    if (width_sum > 6'(SLOT_BITS)) compressible = 1'b0;
    header.min_values = mins;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixels_q       <= '0;
      header_q       <= '0;
      compressible_q <= 1'b0;
    end else begin
      pixels_q       <= pixels;
      header_q       <= header;
      compressible_q <= compressible;
    end
  end

endmodule

// File: rtl/igpu_residual_compressor.sv
// Two-stage minimum + residual compressor: stage 1 in residual_inst,
// stage 2 packs residual slots into the output line register cc_reg.
module igpu_residual_compressor (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] pixels,
  output logic [511:0]  lines,
  output logic [1:0]    flag
);
  import igpu_residual_compressor_pkg::*;

  logic [1023:0] pixels_q;
  logic [47:0]   header_q;
  logic          compressible_q;

  pixels_t       px_q;
  header_t       hdr;
  line_t         line_next;
  line_t         cc_reg;
  logic [1:0]    flag_reg;
  logic [2:0]    w_r, w_g, w_b, w_a;
  logic [4:0]    w_sum;
  logic [13:0]   acc;

  igpu_residual_compressor_residual residual_inst (
    .clk            (clk),
    .rst            (rst),
    .pixels         (pixels),
    .pixels_q       (pixels_q),
    .header_q       (header_q),
    .compressible_q (compressible_q)
  );

  assign px_q = pixels_q;
  assign hdr  = header_q;

  function automatic logic [13:0] residual(input logic [7:0] ch,
                                           input logic [7:0] mn,
                                           input logic [2:0] w);
    logic [7:0] mask;
    mask = (8'd1 << w) - 8'd1;
    return {6'b0, (ch - mn) & mask};
  endfunction

  // Residuals are shifted in channel by channel, then left-justified in the slot.
  always_comb begin
    line_next = '0;
    acc       = '0;
    w_r       = hdr.bits_required[11:9];
    w_g       = hdr.bits_required[8:6];
    w_b       = hdr.bits_required[5:3];
    w_a       = hdr.bits_required[2:0];
    w_sum     = {2'b00, w_r} + {2'b00, w_g} + {2'b00, w_b} + {2'b00, w_a};
    if (compressible_q) begin
      line_next.header = hdr;
      for (int i = 0; i < NUM_PIXELS; i++) begin
        acc = '0;
        acc = (acc << w_r) | residual(px_q.channels.r_channel[i], hdr.min_values.min_r, w_r);
        acc = (acc << w_g) | residual(px_q.channels.g_channel[i], hdr.min_values.min_g, w_g);
        acc = (acc << w_b) | residual(px_q.channels.b_channel[i], hdr.min_values.min_b, w_b);
        acc = (acc << w_a) | residual(px_q.channels.a_channel[i], hdr.min_values.min_a, w_a);
        line_next.pix[i] = acc << (5'(SLOT_BITS) - w_sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_reg   <= '0;
      flag_reg <= FLAG_RAW;
    end else begin
      cc_reg   <= line_next;
      flag_reg <= compressible_q ? FLAG_COMPRESSED : FLAG_RAW;
    end
  end

  assign lines = cc_reg;
  assign flag  = flag_reg;

endmodule

// File: tb/tb_igpu_residual_compressor.sv
// Directed bench for igpu_residual_compressor with hand-derived expected lines.
module tb_igpu_residual_compressor;
  import igpu_residual_compressor_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] pixels;
  logic [511:0]  lines;
  logic [1:0]    flag;

  int            checks = 0;
  int            errors = 0;
  pixels_t       blk;
  logic [511:0]  exp_line;
  logic [511:0]  exp_ramp;
  pixels_t       blk_ramp;

  igpu_residual_compressor dut (
    .clk    (clk),
    .rst    (rst),
    .pixels (pixels),
    .lines  (lines),
    .flag   (flag)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input pixels_t b);
    pixels = b;
  endtask

  task automatic check_output(input string tag, input logic [511:0] obs,
                              input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_pixel(input int i, input int r, input int g, input int b, input int a);
    blk.channels.r_channel[i] = 8'(r);
    blk.channels.g_channel[i] = 8'(g);
    blk.channels.b_channel[i] = 8'(b);
    blk.channels.a_channel[i] = 8'(a);
  endtask

  task automatic wait_two_edges();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic load_uniform();
    for (int i = 0; i < 32; i++) set_pixel(i, 10, 20, 30, 40);
    exp_line = '0;
    exp_line[511:464] = {8'h0A, 8'h14, 8'h1E, 8'h28, 12'h000, 4'h0};
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) set_pixel(i, i, 2 * i, 200, 255);
    exp_line = '0;
    exp_line[511:464] = {8'h00, 8'h00, 8'hC8, 8'hFF, 12'hB80, 4'h0};
    for (int i = 0; i < 32; i++) exp_line[463 - 14 * i -: 14] = {5'(i), 6'(2 * i), 3'b000};
  endtask

  initial begin
    rst    = 1'b1;
    pixels = '0;
    blk    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_lines", lines, '0);
    check_output("reset_flag", {510'b0, flag}, {510'b0, FLAG_RAW});
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] uniform block");
    load_uniform();
    apply_stimulus(blk);
    wait_two_edges();
    check_output("uniform_flag", {510'b0, flag}, {510'b0, 2'b01});
    check_output("uniform_line", lines, exp_line);

    $display("[TB] ramp block r=i g=2i");
    load_ramp();
    blk_ramp = blk;
    exp_ramp = exp_line;
    apply_stimulus(blk);
    wait_two_edges();
    check_output("ramp_flag", {510'b0, flag}, {510'b0, 2'b01});
    check_output("ramp_line", lines, exp_ramp);
    check_output("ramp_pix31", {498'b0, lines[29:16]}, {498'b0, 14'h3FF0});
    check_output("ramp_tail", {496'b0, lines[15:0]}, '0);

    $display("[TB] red span 127");
    for (int i = 0; i < 32; i++) set_pixel(i, (i < 31) ? 4 * i : 127, 5, 5, 5);
    exp_line = '0;
    exp_line[511:464] = {8'h00, 8'h05, 8'h05, 8'h05, 12'hE00, 4'h0};
    for (int i = 0; i < 32; i++)
      exp_line[463 - 14 * i -: 14] = {7'((i < 31) ? 4 * i : 127), 7'b0};
    apply_stimulus(blk);
    wait_two_edges();
    check_output("span127_flag", {510'b0, flag}, {510'b0, 2'b01});
    check_output("span127_bits_r", {509'b0, lines[479:477]}, {509'b0, 3'd7});
    check_output("span127_line", lines, exp_line);

    $display("[TB] red span 128");
    set_pixel(31, 128, 5, 5, 5);
    apply_stimulus(blk);
    wait_two_edges();
    check_output("span128_flag", {510'b0, flag}, {510'b0, 2'b00});
    check_output("span128_line", lines, '0);

    $display("[TB] widths 4/4/3/3");
    for (int i = 0; i < 32; i++) set_pixel(i, i % 16, 15 - (i % 16), i % 8, 7 - (i % 8));
    exp_line = '0;
    exp_line[511:464] = {8'h00, 8'h00, 8'h00, 8'h00, 12'h91B, 4'h0};
    for (int i = 0; i < 32; i++)
      exp_line[463 - 14 * i -: 14] = {4'(i % 16), 4'(15 - (i % 16)), 3'(i % 8), 3'(7 - (i % 8))};
    apply_stimulus(blk);
    wait_two_edges();
    check_output("w14_flag", {510'b0, flag}, {510'b0, 2'b01});
    check_output("w14_pix1", {498'b0, lines[449:436]}, {498'b0, 14'h078E});
    check_output("w14_line", lines, exp_line);

    $display("[TB] widths 4/4/4/3");
    for (int i = 0; i < 32; i++) set_pixel(i, i % 16, 15 - (i % 16), i % 16, 7 - (i % 8));
    apply_stimulus(blk);
    wait_two_edges();
    check_output("w15_flag", {510'b0, flag}, {510'b0, 2'b00});
    check_output("w15_line", lines, '0);

    $display("[TB] back-to-back blocks");
    load_uniform();
    apply_stimulus(blk);
    @(posedge clk);
    #1;
    apply_stimulus(blk_ramp);
    @(posedge clk);
    #1;
    check_output("b2b_first", lines, exp_line);
    @(posedge clk);
    #1;
    check_output("b2b_second", lines, exp_ramp);

    $display("[TB] reset mid-pipeline");
    load_uniform();
    apply_stimulus(blk);
    wait_two_edges();
    check_output("pre_reset_flag", {510'b0, flag}, {510'b0, 2'b01});
    apply_stimulus(blk_ramp);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset_lines", lines, '0);
    check_output("async_reset_flag", {510'b0, flag}, {510'b0, 2'b00});
    @(posedge clk);
    #1;
    check_output("held_reset_flag", {510'b0, flag}, {510'b0, 2'b00});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("post_reset_edge1_flag", {510'b0, flag}, {510'b0, 2'b00});
    check_output("post_reset_edge1_lines", lines, '0);
    @(posedge clk);
    #1;
    check_output("post_reset_edge2_flag", {510'b0, flag}, {510'b0, 2'b01});
    check_output("post_reset_edge2_line", lines, exp_ramp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
